// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch path.
// Holds FSM state encoding, fault codes, the reset NOP and PC classification.
package fetch_pkg;

    typedef enum logic [1:0] {
        REQ   = 2'd0,
        WAIT  = 2'd1,
        VALID = 2'd2,
        FAULT = 2'd3
    } fetch_state_e;

    localparam logic [1:0] FC_NONE     = 2'd0;
    localparam logic [1:0] FC_MISALIGN = 2'd1;
    localparam logic [1:0] FC_RANGE    = 2'd2;
    localparam logic [1:0] FC_TIMEOUT  = 2'd3;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // Misalignment is reported in preference to an out-of-range PC.
    function automatic logic [1:0] pc_fault(input logic [31:0] pc, input int addr_w);
        if (pc[1:0] != 2'b00) begin
            return FC_MISALIGN;
        end
        if ((pc >> (addr_w + 2)) != 32'd0) begin
            return FC_RANGE;
        end
        return FC_NONE;
    endfunction

endpackage

// File: rtl/instr_fetch.sv
// Stall-capable instruction fetch: one word read per PC over req/gnt/rvalid,
// result held on instr until the core commits it, with sticky fault reporting.
module instr_fetch
    import fetch_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       pc_address,
    input  logic              instr_ready,
    output logic [31:0]       instr,
    output logic              instr_valid,
    output logic              fetch_fault,
    output logic [1:0]        fault_code,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    fetch_state_e     state;
    fetch_state_e     state_next;
    logic [1:0]       fault_next;
    logic [1:0]       pc_code;
    logic [CNT_W-1:0] tmo_cnt;
    logic             tmo_hit;

    assign pc_code = pc_fault(pc_address, ADDR_W);

    // The count would reach TIMEOUT on this edge, so a waiting state gives up now.
    assign tmo_hit = (tmo_cnt == CNT_W'(TIMEOUT - 1));

    assign mem_addr = pc_address[ADDR_W+1:2];
    assign mem_req  = rst && (state == REQ) && (pc_code == FC_NONE);

    // NOTE: every signal written in always_comb gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        fault_next = FC_NONE;
        case (state)
            REQ: begin
                if (pc_code != FC_NONE) begin
                    state_next = FAULT;
                    fault_next = pc_code;
                end else if (mem_gnt) begin
                    state_next = WAIT;
                end else if (tmo_hit) begin
                    state_next = FAULT;
                    fault_next = FC_TIMEOUT;
                end
            end
            WAIT: begin
                if (mem_rvalid) begin
                    state_next = VALID;
                end else if (tmo_hit) begin
                    state_next = FAULT;
                    fault_next = FC_TIMEOUT;
                end
            end
            VALID: begin
                if (instr_ready) begin
                    state_next = REQ;
                end
            end
            FAULT: begin
                state_next = FAULT;
            end
            default: begin
                state_next = REQ;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= REQ;
            instr_valid <= 1'b0;
            fetch_fault <= 1'b0;
            fault_code  <= FC_NONE;
        end else begin
            state       <= state_next;
            instr_valid <= (state_next == VALID);
            fetch_fault <= (state_next == FAULT);
            if (state != FAULT && state_next == FAULT) begin
                fault_code <= fault_next;
            end
        end
    end

    // Cleared on every state change; leaving at TIMEOUT-1 keeps it from wrapping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tmo_cnt <= '0;
        end else if (state_next != state) begin
            tmo_cnt <= '0;
        end else if (state == REQ || state == WAIT) begin
            tmo_cnt <= tmo_cnt + CNT_W'(1);
        end
    end

    // Only a response to our own outstanding request is captured; late data in FAULT is dropped.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            instr <= NOP_INSTR;
        end else if (state == WAIT && mem_rvalid) begin
            instr <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: default-parameter instance plus a TIMEOUT=4 instance
// sharing stimulus; fetched words are scoreboarded through a queue.
module tb_instr_fetch;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_address;
    logic        instr_ready;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    logic [31:0] a_instr,  t_instr;
    logic        a_instr_valid, t_instr_valid;
    logic        a_fetch_fault, t_fetch_fault;
    logic [1:0]  a_fault_code,  t_fault_code;
    logic        a_mem_req,     t_mem_req;
    logic [7:0]  a_mem_addr,    t_mem_addr;

    int passed = 0;
    int total  = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    instr_fetch #(.ADDR_W(8), .TIMEOUT(255)) dut_a (
        .clk(clk), .rst(rst), .pc_address(pc_address), .instr_ready(instr_ready),
        .instr(a_instr), .instr_valid(a_instr_valid), .fetch_fault(a_fetch_fault),
        .fault_code(a_fault_code), .mem_req(a_mem_req), .mem_addr(a_mem_addr),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    instr_fetch #(.ADDR_W(8), .TIMEOUT(4)) dut_t (
        .clk(clk), .rst(rst), .pc_address(pc_address), .instr_ready(instr_ready),
        .instr(t_instr), .instr_valid(t_instr_valid), .fetch_fault(t_fetch_fault),
        .fault_code(t_fault_code), .mem_req(t_mem_req), .mem_addr(t_mem_addr),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    // Inputs change on the falling edge; outputs are sampled 1 time unit later.
    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive_reset(input logic [31:0] pc);
        rst         = 1'b0;
        pc_address  = pc;
        instr_ready = 1'b0;
        mem_gnt     = 1'b0;
        mem_rvalid  = 1'b0;
        mem_rdata   = 32'h0;
        repeat (2) cyc();
        rst = 1'b1;
    endtask

    // Memory model: grant after gd stall cycles, return data after rd stall cycles.
    task automatic fetch_word(input logic [31:0] pc, input logic [31:0] data,
                              input int gd, input int rd, input string tag);
        logic [7:0]  wa;
        logic [31:0] exp;
        wa = pc[9:2];
        pc_address = pc;
        exp_q.push_back(data);
        for (int i = 0; i <= gd; i++) begin
            mem_gnt = (i == gd);
            #1;
            total++;
            if (a_mem_req !== 1'b1) $display("FAIL %s req c%0d: got %b want 1", tag, i, a_mem_req);
            else passed++;
            total++;
            if (a_mem_addr !== wa) $display("FAIL %s addr c%0d: got %h want %h", tag, i, a_mem_addr, wa);
            else passed++;
            cyc();
        end
        mem_gnt = 1'b0;
        for (int i = 0; i <= rd; i++) begin
            mem_rvalid = (i == rd);
            mem_rdata  = (i == rd) ? data : $urandom();
            #1;
            total++;
            if (a_mem_req !== 1'b0 || a_instr_valid !== 1'b0)
                $display("FAIL %s wait c%0d: req=%b valid=%b want 0/0", tag, i, a_mem_req, a_instr_valid);
            else passed++;
            cyc();
        end
        mem_rvalid = 1'b0;
        mem_rdata  = $urandom();
        #1;
        total++;
        if (a_instr_valid !== 1'b1) $display("FAIL %s valid: got %b want 1", tag, a_instr_valid);
        else passed++;
        total++;
        if (exp_q.size() == 0) begin
            $display("FAIL %s scoreboard: queue empty when instr_valid seen", tag);
        end else begin
            exp = exp_q.pop_front();
            if (a_instr !== exp) $display("FAIL %s instr: got %h want %h", tag, a_instr, exp);
            else passed++;
        end
    endtask

    // Core commits; its PC moves on the same edge.
    task automatic retire(input logic [31:0] next_pc);
        instr_ready = 1'b1;
        cyc();
        instr_ready = 1'b0;
        pc_address  = next_pc;
        #1;
        total++;
        if (a_instr_valid !== 1'b0) $display("FAIL retire valid drop: got %b want 0", a_instr_valid);
        else passed++;
    endtask

    task automatic test_reset();
        rst         = 1'b0;
        pc_address  = 32'h0;
        instr_ready = 1'b0;
        mem_gnt     = 1'b0;
        mem_rvalid  = 1'b0;
        mem_rdata   = 32'h0;
        #1;
        total++;
        if (a_instr !== NOP || t_instr !== NOP) $display("FAIL reset instr: got %h/%h want %h", a_instr, t_instr, NOP);
        else passed++;
        total++;
        if (a_instr_valid !== 1'b0 || a_fetch_fault !== 1'b0 || a_fault_code !== 2'd0)
            $display("FAIL reset flags: valid=%b fault=%b code=%0d want 0/0/0", a_instr_valid, a_fetch_fault, a_fault_code);
        else passed++;
        total++;
        if (a_mem_req !== 1'b0) $display("FAIL reset req: got %b want 0", a_mem_req);
        else passed++;
        repeat (2) cyc();
        rst = 1'b1;
    endtask

    task automatic test_basic();
        fetch_word(32'h0, 32'h0050_0093, 0, 0, "basic");
    endtask

    task automatic test_hold();
        for (int i = 0; i < 10; i++) begin
            #1;
            total++;
            if (a_instr !== 32'h0050_0093 || a_instr_valid !== 1'b1 || a_mem_req !== 1'b0)
                $display("FAIL hold c%0d: instr=%h valid=%b req=%b want 00500093/1/0", i, a_instr, a_instr_valid, a_mem_req);
            else passed++;
            cyc();
        end
        retire(32'h4);
        fetch_word(32'h4, 32'h00A0_0113, 0, 0, "hold_next");
    endtask

    task automatic test_delay();
        retire(32'h8);
        fetch_word(32'h8, 32'hDEAD_BEEF, 3, 5, "delay");
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 6; k++) begin
            retire(32'hC + 32'(4 * k));
            fetch_word(32'hC + 32'(4 * k), $urandom(), k % 3, (k + 1) % 3, "b2b");
        end
        retire(32'h3FC);
        fetch_word(32'h3FC, 32'h7777_1111, 0, 0, "top_pc");
    endtask

    task automatic test_bad_pc();
        logic [31:0] pcs   [4];
        logic [1:0]  codes [4];
        pcs   = '{32'h6, 32'h400, 32'h402, 32'h8000_0000};
        codes = '{2'd1, 2'd2, 2'd1, 2'd2};
        for (int k = 0; k < 4; k++) begin
            drive_reset(pcs[k]);
            for (int i = 0; i < 3; i++) begin
                #1;
                total++;
                if (a_mem_req !== 1'b0) $display("FAIL badpc %h req c%0d: got %b want 0", pcs[k], i, a_mem_req);
                else passed++;
                cyc();
            end
            #1;
            total++;
            if (a_fetch_fault !== 1'b1 || a_fault_code !== codes[k] || a_instr_valid !== 1'b0 || a_instr !== NOP)
                $display("FAIL badpc %h: fault=%b code=%0d valid=%b instr=%h want 1/%0d/0/%h",
                         pcs[k], a_fetch_fault, a_fault_code, a_instr_valid, a_instr, codes[k], NOP);
            else passed++;
        end
    endtask

    task automatic test_timeout();
        drive_reset(32'h0);
        fetch_word(32'h0, 32'h1234_5678, 0, 0, "to_pre");
        total++;
        if (t_instr !== 32'h1234_5678 || t_instr_valid !== 1'b1)
            $display("FAIL to_pre t: instr=%h valid=%b want 12345678/1", t_instr, t_instr_valid);
        else passed++;
        retire(32'h4);
        mem_gnt = 1'b1;
        #1;
        total++;
        if (t_mem_req !== 1'b1) $display("FAIL to req: got %b want 1", t_mem_req);
        else passed++;
        cyc();
        mem_gnt = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            total++;
            if (t_fetch_fault !== 1'b0 || t_mem_req !== 1'b0)
                $display("FAIL to wait c%0d: fault=%b req=%b want 0/0", i, t_fetch_fault, t_mem_req);
            else passed++;
            cyc();
        end
        #1;
        total++;
        if (t_fetch_fault !== 1'b1 || t_fault_code !== 2'd3 || t_instr_valid !== 1'b0)
            $display("FAIL to fault: fault=%b code=%0d valid=%b want 1/3/0", t_fetch_fault, t_fault_code, t_instr_valid);
        else passed++;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hBAD0_BAD0;
        cyc();
        mem_rvalid = 1'b0;
        #1;
        total++;
        if (t_instr !== 32'h1234_5678 || t_instr_valid !== 1'b0 || t_fetch_fault !== 1'b1)
            $display("FAIL to late rvalid: instr=%h valid=%b fault=%b want 12345678/0/1", t_instr, t_instr_valid, t_fetch_fault);
        else passed++;
    endtask

    task automatic test_gnt_boundary();
        drive_reset(32'h40);
        for (int i = 0; i < 4; i++) begin
            mem_gnt = (i == 3);
            #1;
            total++;
            if (t_mem_req !== 1'b1 || t_mem_addr !== 8'h10)
                $display("FAIL gnt_edge req c%0d: req=%b addr=%h want 1/10", i, t_mem_req, t_mem_addr);
            else passed++;
            cyc();
        end
        mem_gnt = 1'b0;
        #1;
        total++;
        if (t_fetch_fault !== 1'b0) $display("FAIL gnt_edge fault: got %b want 0", t_fetch_fault);
        else passed++;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hCAFE_0001;
        cyc();
        mem_rvalid = 1'b0;
        #1;
        total++;
        if (t_instr_valid !== 1'b1 || t_instr !== 32'hCAFE_0001)
            $display("FAIL gnt_edge data: valid=%b instr=%h want 1/cafe0001", t_instr_valid, t_instr);
        else passed++;
        drive_reset(32'h40);
        for (int i = 0; i < 4; i++) begin
            #1;
            total++;
            if (t_fetch_fault !== 1'b0) $display("FAIL req_to c%0d: fault=%b want 0", i, t_fetch_fault);
            else passed++;
            cyc();
        end
        #1;
        total++;
        if (t_fetch_fault !== 1'b1 || t_fault_code !== 2'd3 || t_mem_req !== 1'b0)
            $display("FAIL req_to fault: fault=%b code=%0d req=%b want 1/3/0", t_fetch_fault, t_fault_code, t_mem_req);
        else passed++;
    endtask

    task automatic test_reset_mid();
        drive_reset(32'h20);
        fetch_word(32'h20, 32'h0BAD_F00D, 0, 0, "mid_pre");
        retire(32'h24);
        mem_gnt = 1'b1;
        cyc();
        mem_gnt = 1'b0;
        rst = 1'b0;
        #1;
        total++;
        if (a_instr !== NOP || a_instr_valid !== 1'b0 || a_mem_req !== 1'b0 || a_fetch_fault !== 1'b0)
            $display("FAIL mid reset: instr=%h valid=%b req=%b fault=%b want %h/0/0/0",
                     a_instr, a_instr_valid, a_mem_req, a_fetch_fault, NOP);
        else passed++;
        pc_address = 32'h28;
        cyc();
        rst = 1'b1;
        fetch_word(32'h28, 32'h0030_0193, 0, 0, "mid_restart");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk);
        test_reset();
        test_basic();
        test_hold();
        test_delay();
        test_back_to_back();
        test_bad_pc();
        test_timeout();
        test_gnt_boundary();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
